// File: rtl/led_pattern_monitor.sv
// Receive-side checker for the bounce-flasher LED bus.
// Registers LED/flick once. On the next edge it decodes the thermometer code into a level.
// An internal phase tracker predicts the next level and reports two kinds of error:
// malformed codes and sequence violations.
module led_pattern_monitor #(
  parameter int LED_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [LED_W-1:0]           LED,
  input  logic                       flick,
  input  logic                       clr_err,
  output logic [$clog2(LED_W+1)-1:0] level,
  output logic [2:0]                 phase,
  output logic                       code_err,
  output logic                       seq_err,
  output logic                       err_seen,
  output logic [CNT_W-1:0]           err_count
);
  localparam int LW = $clog2(LED_W+1);

  // Turning points of the bounce pattern (tuned for a 16-wide bus)
  localparam logic [LW-1:0] L_ZERO   = '0;
  localparam logic [LW-1:0] L_ONE    = LW'(1);
  localparam logic [LW-1:0] L_FIVE   = LW'(5);
  localparam logic [LW-1:0] L_SIX    = LW'(6);
  localparam logic [LW-1:0] L_TEN    = LW'(10);
  localparam logic [LW-1:0] L_ELEVEN = LW'(11);
  localparam logic [LW-1:0] L_TOP    = LW'(LED_W);
  localparam logic [LW-1:0] L_TOP_M1 = LW'(LED_W-1);

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_UP6  = 3'd1,
    PH_DN0  = 3'd2,
    PH_UP11 = 3'd3,
    PH_DN5  = 3'd4,
    PH_UP16 = 3'd5,
    PH_LOST = 3'd7
  } phase_t;

  logic [LED_W-1:0] r_s_led;
  logic             r_s_flick;
  logic [LW-1:0]    r_level;
  phase_t           r_phase;
  logic [LW-1:0]    r_exp;
  logic             r_zero;
  logic             r_code_err;
  logic             r_seq_err;
  logic             r_err_seen;
  logic [CNT_W-1:0] r_err_count;

  logic [LED_W-2:0] w_mono;
  logic             w_valid;
  logic [LW-1:0]    w_lvl;
  logic             w_kick;
  logic             w_tracking;
  logic             w_code_err;
  logic             w_seq_err;
  logic             w_err;
  phase_t           w_phase_next;
  logic [LW-1:0]    w_exp_next;
  logic [LW-1:0]    w_level_next;
  logic             w_zero_next;

  // A thermometer code never has a lit LED above an unlit one
  genvar gi;
  generate
    for (gi = 0; gi < LED_W-1; gi++) begin : g_mono
      assign w_mono[gi] = r_s_led[gi] | ~r_s_led[gi+1];
    end
  endgenerate
  assign w_valid = &w_mono;

  // Level is the number of lit LEDs (only meaningful when the code is valid)
  always_comb begin
    w_lvl = '0;
    for (int i = 0; i < LED_W; i++) begin
      w_lvl = w_lvl + LW'(r_s_led[i]);
    end
  end

  // Next-state and prediction logic for the phase tracker
  always_comb begin
    w_phase_next = r_phase;
    w_exp_next   = r_exp;
    w_level_next = r_level;
    w_zero_next  = r_zero;
    w_code_err   = 1'b0;
    w_seq_err    = 1'b0;
    w_kick       = r_s_flick && (w_lvl == L_SIX || w_lvl == L_ELEVEN);
    // The unused encoding 6 is handled like LOST
    w_tracking   = (r_phase <= PH_UP16);

    if (!w_valid) begin
      w_code_err   = 1'b1;
      w_phase_next = PH_LOST;
      w_zero_next  = 1'b0;
    end else begin
      w_level_next = w_lvl;
      if (!w_tracking) begin
        // Resynchronise on two consecutive empty-bus samples, then act as IDLE at level 0
        if (w_lvl == L_ZERO) begin
          if (r_zero) begin
            w_zero_next = 1'b0;
            if (r_s_flick) begin
              w_exp_next   = L_ONE;
              w_phase_next = PH_UP6;
            end else begin
              w_exp_next   = L_ZERO;
              w_phase_next = PH_IDLE;
            end
          end else begin
            w_zero_next = 1'b1;
          end
        end else begin
          w_zero_next = 1'b0;
        end
      end else if (w_lvl != r_exp) begin
        w_seq_err    = 1'b1;
        w_phase_next = PH_LOST;
        w_zero_next  = 1'b0;
      end else begin
        case (r_phase)
          PH_IDLE: begin
            if (w_lvl != L_ZERO) begin
              w_exp_next = w_lvl - L_ONE;
            end else if (r_s_flick) begin
              w_exp_next   = L_ONE;
              w_phase_next = PH_UP6;
            end else begin
              w_exp_next = L_ZERO;
            end
          end
          PH_UP6: begin
            if (w_lvl == L_SIX) begin
              w_exp_next   = L_FIVE;
              w_phase_next = PH_DN0;
            end else begin
              w_exp_next = w_lvl + L_ONE;
            end
          end
          PH_DN0: begin
            if (w_lvl == L_ZERO) begin
              w_exp_next   = L_ONE;
              w_phase_next = PH_UP11;
            end else begin
              w_exp_next = w_lvl - L_ONE;
            end
          end
          PH_UP11: begin
            if (w_kick) begin
              w_exp_next   = w_lvl - L_ONE;
              w_phase_next = PH_DN0;
            end else if (w_lvl == L_ELEVEN) begin
              w_exp_next   = L_TEN;
              w_phase_next = PH_DN5;
            end else begin
              w_exp_next = w_lvl + L_ONE;
            end
          end
          PH_DN5: begin
            if (w_lvl == L_FIVE) begin
              w_exp_next   = L_SIX;
              w_phase_next = PH_UP16;
            end else begin
              w_exp_next = w_lvl - L_ONE;
            end
          end
          PH_UP16: begin
            if (w_kick) begin
              w_exp_next   = w_lvl - L_ONE;
              w_phase_next = PH_DN5;
            end else if (w_lvl == L_TOP) begin
              w_exp_next   = L_TOP_M1;
              w_phase_next = PH_IDLE;
            end else begin
              w_exp_next = w_lvl + L_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign w_err = w_code_err | w_seq_err;

  // Input stage, tracker state and error accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_led     <= '0;
      r_s_flick   <= 1'b0;
      r_level     <= '0;
      r_phase     <= PH_IDLE;
      r_exp       <= '0;
      r_zero      <= 1'b0;
      r_code_err  <= 1'b0;
      r_seq_err   <= 1'b0;
      r_err_seen  <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_s_led    <= LED;
      r_s_flick  <= flick;
      r_level    <= w_level_next;
      r_phase    <= w_phase_next;
      r_exp      <= w_exp_next;
      r_zero     <= w_zero_next;
      r_code_err <= w_code_err;
      r_seq_err  <= w_seq_err;
      // A clear coinciding with an error leaves exactly that one error recorded
      if (clr_err) begin
        r_err_seen  <= w_err;
        r_err_count <= CNT_W'(w_err);
      end else if (w_err) begin
        r_err_seen <= 1'b1;
        if (r_err_count != {CNT_W{1'b1}}) begin
          r_err_count <= r_err_count + CNT_W'(1);
        end
      end
    end
  end

  assign level     = r_level;
  assign phase     = r_phase;
  assign code_err  = r_code_err;
  assign seq_err   = r_seq_err;
  assign err_seen  = r_err_seen;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_led_pattern_monitor.sv
// Bench for led_pattern_monitor. Drives directed LED/flick sequences into two instances.
// The instances use an 8-bit and a 2-bit error counter. Outputs are checked every cycle
// against a table-driven bounce model, plus a few fixed expectations.
module tb_led_pattern_monitor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] LED = '0;
  logic        flick = 1'b0;
  logic        clr_err = 1'b0;

  logic [4:0] level, level2;
  logic [2:0] phase, phase2;
  logic       code_err, seq_err, err_seen;
  logic       code_err2, seq_err2, err_seen2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  led_pattern_monitor #(.LED_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .LED(LED), .flick(flick), .clr_err(clr_err),
    .level(level), .phase(phase), .code_err(code_err), .seq_err(seq_err),
    .err_seen(err_seen), .err_count(err_count)
  );

  led_pattern_monitor #(.LED_W(16), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .LED(LED), .flick(flick), .clr_err(clr_err),
    .level(level2), .phase(phase2), .code_err(code_err2), .seq_err(seq_err2),
    .err_seen(err_seen2), .err_count(err_count2)
  );

  // ---------------- behavioural model ----------------
  // The bounce: each phase moves in one direction until its turning level.
  // It then reverses and moves on to the next phase, cyclically over 0..5.
  int turn_at [6] = '{0, 6, 0, 11, 5, 16};
  int dir_of  [6] = '{-1, 1, -1, 1, -1, 1};

  int m_sled, m_sflick;
  int m_level, m_p, m_exp, m_zrun;
  bit m_lost;
  int m_ce, m_se, m_seen, m_cnt, m_cnt2;

  task automatic model_reset();
    m_sled = 0; m_sflick = 0; m_level = 0; m_p = 0; m_exp = 0; m_zrun = 0;
    m_lost = 0; m_ce = 0; m_se = 0; m_seen = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic model_advance(input int L, input int f);
    if (m_p == 0 && L == 0 && f == 0) begin
      m_exp = 0;
    end else if ((m_p == 3 || m_p == 5) && f != 0 && (L == 6 || L == 11)) begin
      m_exp = L - 1;
      m_p   = m_p - 1;
    end else if (L == turn_at[m_p]) begin
      m_exp = L - dir_of[m_p];
      m_p   = (m_p + 1) % 6;
    end else begin
      m_exp = L + dir_of[m_p];
    end
  endtask

  task automatic model_step();
    int L;
    int err;
    L = $countones(m_sled);
    m_ce = 0;
    m_se = 0;
    if (m_sled != ((1 << L) - 1)) begin
      m_ce = 1; m_lost = 1; m_zrun = 0;
    end else begin
      m_level = L;
      if (m_lost) begin
        m_zrun = (L == 0) ? m_zrun + 1 : 0;
        if (m_zrun >= 2) begin
          m_lost = 0; m_zrun = 0; m_p = 0;
          model_advance(0, m_sflick);
        end
      end else if (L != m_exp) begin
        m_se = 1; m_lost = 1; m_zrun = 0;
      end else begin
        model_advance(L, m_sflick);
      end
    end
    err = m_ce | m_se;
    if (clr_err) begin
      m_seen = err; m_cnt = err; m_cnt2 = err;
    end else if (err != 0) begin
      m_seen = 1;
      m_cnt  = (m_cnt  < 255) ? m_cnt + 1  : 255;
      m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
    end
    m_sled   = LED;
    m_sflick = flick;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      check("level", 32'(level), 32'(m_level));
      check("phase", 32'(phase), 32'(m_lost ? 7 : m_p));
      check("code_err", 32'(code_err), 32'(m_ce));
      check("seq_err", 32'(seq_err), 32'(m_se));
      check("err_seen", 32'(err_seen), 32'(m_seen));
      check("err_count", 32'(err_count), 32'(m_cnt));
      check("phase2", 32'(phase2), 32'(m_lost ? 7 : m_p));
      check("err_count2", 32'(err_count2), 32'(m_cnt2));
    end
  end

  // ---------------- stimulus ----------------
  task automatic put_raw(input logic [15:0] v, input logic f);
    LED = v;
    flick = f;
    @(negedge clk);
    $display("sample LED=%h flick=%0d -> level=%0d phase=%0d code_err=%0d seq_err=%0d err_count=%0d",
             v, f, level, phase, code_err, seq_err, err_count);
  endtask

  task automatic put(input int L, input logic f);
    logic [16:0] t;
    t = (17'd1 << L) - 17'd1;
    put_raw(t[15:0], f);
  endtask

  task automatic ramp(input int a, input int b);
    if (a <= b) for (int i = a; i <= b; i++) put(i, 1'b0);
    else        for (int i = a; i >= b; i--) put(i, 1'b0);
  endtask

  task automatic to_idle();
    put(0, 1'b0); put(0, 1'b0); put(0, 1'b0);
    clr_err = 1'b1;
    put(0, 1'b0);
    clr_err = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_level", 32'(level), 0);
    check("rst_phase", 32'(phase), 0);
    rst_n = 1'b1;
    // 1: quiet bus after reset
    repeat (10) @(negedge clk);
    check("t1_phase", 32'(phase), 0);
    check("t1_count", 32'(err_count), 0);

    // 2: golden run
    put(0, 1'b1); put(1, 1'b0);
    check("g_up6", 32'(phase), 1);
    ramp(2, 6); put(5, 1'b0);
    check("g_dn0", 32'(phase), 2);
    ramp(4, 0); put(1, 1'b0);
    check("g_up11", 32'(phase), 3);
    ramp(2, 11); put(10, 1'b0);
    check("g_dn5", 32'(phase), 4);
    ramp(9, 5); put(6, 1'b0);
    check("g_up16", 32'(phase), 5);
    ramp(7, 16); put(15, 1'b0);
    check("g_idle", 32'(phase), 0);
    ramp(14, 0); put(0, 1'b0);
    check("g_count", 32'(err_count), 0);

    // 3: legal kickbacks in UP11 and UP16
    put(0, 1'b1); ramp(1, 6); ramp(5, 0); ramp(1, 5);
    put(6, 1'b1); put(5, 1'b0);
    check("k11_phase", 32'(phase), 2);
    put(4, 1'b0);
    check("k11_seq", 32'(seq_err), 0);
    ramp(3, 0); ramp(1, 11); ramp(10, 5); ramp(6, 10);
    put(11, 1'b1); put(10, 1'b0);
    check("k16_phase", 32'(phase), 4);
    put(9, 1'b0);
    check("k16_seq", 32'(seq_err), 0);
    ramp(8, 5); ramp(6, 16); ramp(15, 0); put(0, 1'b0);
    check("k_count", 32'(err_count), 0);

    // 3: same drops without flick
    put(0, 1'b1); ramp(1, 6); ramp(5, 0); ramp(1, 6); put(5, 1'b0); put(0, 1'b0);
    check("k11_noflick", 32'(seq_err), 1);
    to_idle();
    put(0, 1'b1); ramp(1, 6); ramp(5, 0); ramp(1, 11); ramp(10, 5); ramp(6, 11);
    put(10, 1'b0); put(0, 1'b0);
    check("k16_noflick", 32'(seq_err), 1);
    to_idle();

    // 4: malformed code
    put(0, 1'b1); put(1, 1'b0); put(2, 1'b0); put_raw(16'h0005, 1'b0); put(0, 1'b0);
    check("ce_pulse", 32'(code_err), 1);
    check("ce_level", 32'(level), 2);
    check("ce_phase", 32'(phase), 7);
    check("ce_count", 32'(err_count), 1);
    put(0, 1'b0); put(0, 1'b0);
    check("ce_recover", 32'(phase), 0);
    to_idle();

    // 5: skips
    put(0, 1'b1); ramp(1, 3); put(5, 1'b0); put(0, 1'b0);
    check("skip6_seq", 32'(seq_err), 1);
    put(0, 1'b0);
    check("skip6_count", 32'(err_count), 1);
    to_idle();
    put(0, 1'b1); ramp(1, 6); ramp(5, 0); ramp(1, 11); put(12, 1'b0); put(0, 1'b0);
    check("skip11_seq", 32'(seq_err), 1);
    to_idle();

    // 6: saturation and clear-with-error
    repeat (5) put_raw(16'h0005, 1'b0);
    put(0, 1'b0);
    check("sat_count8", 32'(err_count), 5);
    check("sat_count2", 32'(err_count2), 3);
    put_raw(16'h0005, 1'b0);
    clr_err = 1'b1;
    put(0, 1'b0);
    clr_err = 1'b0;
    check("clr_count", 32'(err_count), 1);
    check("clr_seen", 32'(err_seen), 1);
    check("clr_count2", 32'(err_count2), 1);

    // 6: reset in the middle of activity
    put(3, 1'b0); put(3, 1'b0);
    #2 rst_n = 1'b0;
    LED = '0;
    #1;
    check("mrst_level", 32'(level), 0);
    check("mrst_phase", 32'(phase), 0);
    check("mrst_seen", 32'(err_seen), 0);
    check("mrst_count", 32'(err_count), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    put(0, 1'b1); ramp(1, 6); put(5, 1'b0);
    check("mrst_restart", 32'(phase), 2);
    check("mrst_clean", 32'(err_count), 0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
